// File: rtl/mac_pkg.sv
// Shared types for the MAC result drain: drain FSM states and accumulator width helper.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2
    } drain_state_t;

    // Accumulator is wide enough for a full dot product of DATA_WIDTH operands.
    function automatic int acc_w(input int data_width);
        return 3 * data_width;
    endfunction

endpackage

// File: rtl/mac_drain_bank.sv
// Shadow capture bank for the MAC accumulators plus the lane read mux.
// Capture is a single-cycle load of every lane; contents survive reset on purpose.
module mac_drain_bank #(
    parameter int NUM_MAC = 8,
    parameter int ACC_W   = 24,
    parameter int IDX_W   = $clog2(NUM_MAC)
) (
    input  logic                     clk,
    input  logic                     cap_en_i,
    input  logic [NUM_MAC*ACC_W-1:0] couts_flat_i,
    input  logic [IDX_W-1:0]         rd_idx_i,
    output logic [ACC_W-1:0]         rd_dat_o
);

    logic [ACC_W-1:0] bank_q [NUM_MAC];

    always_ff @(posedge clk) begin
        if (cap_en_i) begin
            for (int i = 0; i < NUM_MAC; i++) begin
                bank_q[i] <= couts_flat_i[i*ACC_W +: ACC_W];
            end
        end
    end

    assign rd_dat_o = bank_q[rd_idx_i];

endmodule

// File: rtl/mac_result_drain.sv
// Snapshots a MAC row, pulses Clr for one cycle, then streams lanes out over valid/ready.
// Optional MAC_DRAIN_ERR_EN adds a sticky start_err flag for starts received while busy.
module mac_result_drain
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_MAC    = 8,
    localparam int ACC_W     = acc_w(DATA_WIDTH),
    localparam int IDX_W     = $clog2(NUM_MAC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NUM_MAC*ACC_W-1:0] couts_flat,
    output logic                     mac_clr,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     done
`ifdef MAC_DRAIN_ERR_EN
    ,
    output logic                     start_err
`endif
);

    drain_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             capture;
    logic             last_lane;
    logic [ACC_W-1:0] rd_dat;

    assign last_lane = (idx_q == IDX_W'(NUM_MAC - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = STREAM;
                idx_d   = '0;
            end
            STREAM: begin
                if (out_ready) begin
                    if (last_lane) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Reset must also block a capture, even though the bank itself is never cleared.
    mac_drain_bank #(
        .NUM_MAC (NUM_MAC),
        .ACC_W   (ACC_W),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk          (clk),
        .cap_en_i     (capture & rst_n),
        .couts_flat_i (couts_flat),
        .rd_idx_i     (idx_q),
        .rd_dat_o     (rd_dat)
    );

    assign mac_clr   = (state_q == CLEAR);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == STREAM);
    assign out_data  = out_valid ? rd_dat : '0;
    assign out_idx   = idx_q;
    assign out_last  = out_valid & last_lane;
    assign done      = done_q;

`ifdef MAC_DRAIN_ERR_EN
    logic start_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_err_q <= 1'b0;
        end else if (start && busy) begin
            start_err_q <= 1'b1;
        end
    end

    assign start_err = start_err_q;
`endif

endmodule
